// File: rtl/bf_control_if.sv
// Bus bundle between the brainfuck sequencer and its instruction ROM, data RAM, ALU and byte I/O.
// master = controller side, slave = memories/ALU/IO side.
interface bf_control_if #(
    parameter int WIDTH   = 8,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 8
);
    logic [IADDR_W-1:0] imem_addr;
    logic [7:0]         imem_data;
    logic [DADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]   dmem_rdata;
    logic [WIDTH-1:0]   dmem_wdata;
    logic               dmem_we;
    logic [WIDTH-1:0]   alu_a;
    logic               alu_nochange;
    logic               alu_decrement;
    logic               alu_increment;
    logic [WIDTH-1:0]   alu_out;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;

    modport master (
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, alu_a,
               alu_nochange, alu_decrement, alu_increment,
               out_valid, out_data, in_ready,
        input  imem_data, dmem_rdata, alu_out, out_ready, in_valid, in_data
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, alu_a,
               alu_nochange, alu_decrement, alu_increment,
               out_valid, out_data, in_ready,
        output imem_data, dmem_rdata, alu_out, out_ready, in_valid, in_data
    );
endinterface

// File: rtl/bf_control.sv
// Brainfuck instruction sequencer: fetch/decode/execute, pointer moves, bracket scanning
// with a depth counter, and valid/ready byte I/O.
module bf_control #(
    parameter int WIDTH   = 8,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 8,
    parameter int DEPTH_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    bf_control_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         error
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC     = 4'd3;
    localparam logic [3:0] S_OUT_WAIT = 4'd4;
    localparam logic [3:0] S_IN_WAIT  = 4'd5;
    localparam logic [3:0] S_SFETCH   = 4'd6;
    localparam logic [3:0] S_SCHECK   = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;

    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;

    logic [3:0]         state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [DADDR_W-1:0] dp_q, dp_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               dir_q, dir_d;      // 0 = forward scan, 1 = backward scan
    logic [7:0]         op_q, op_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               error_q, error_d;

    logic [IADDR_W:0]   pc_inc;
    logic               advance, retreat;
    logic [3:0]         adv_state;
    logic               nest, unnest;

    assign pc_inc = {1'b0, pc_q} + (IADDR_W+1)'(1);
    assign nest   = dir_q ? (bus.imem_data == OP_CLOSE) : (bus.imem_data == OP_OPEN);
    assign unnest = dir_q ? (bus.imem_data == OP_OPEN)  : (bus.imem_data == OP_CLOSE);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        dp_d      = dp_q;
        depth_d   = depth_q;
        dir_d     = dir_q;
        op_d      = op_q;
        out_d     = out_q;
        error_d   = error_q;
        advance   = 1'b0;
        retreat   = 1'b0;
        adv_state = S_FETCH;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    dp_d    = '0;
                    depth_d = '0;
                    error_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.imem_data;
                case (bus.imem_data)
                    OP_RIGHT: begin dp_d = dp_q + DADDR_W'(1); advance = 1'b1; end
                    OP_LEFT:  begin dp_d = dp_q - DADDR_W'(1); advance = 1'b1; end
                    8'h00:    state_d = S_HALT;
                    OP_INC, OP_DEC, OP_OUT, OP_IN, OP_OPEN, OP_CLOSE: state_d = S_EXEC;
                    default:  advance = 1'b1;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_OUT: begin out_d = bus.dmem_rdata; state_d = S_OUT_WAIT; end
                    OP_IN:  state_d = S_IN_WAIT;
                    OP_OPEN: begin
                        advance = 1'b1;
                        if (bus.dmem_rdata == '0) begin
                            depth_d   = DEPTH_W'(1);
                            dir_d     = 1'b0;
                            adv_state = S_SCHECK - 4'd1;
                        end
                    end
                    OP_CLOSE: begin
                        if (bus.dmem_rdata == '0) begin
                            advance = 1'b1;
                        end else begin
                            depth_d = DEPTH_W'(1);
                            dir_d   = 1'b1;
                            retreat = 1'b1;
                        end
                    end
                    default: advance = 1'b1;
                endcase
            end
            S_OUT_WAIT: advance = bus.out_ready;
            S_IN_WAIT:  advance = bus.in_valid;
            S_SFETCH:   state_d = S_SCHECK;
            S_SCHECK: begin
                if (bus.imem_data == 8'h00 || (nest && depth_q == '1)) begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    if (nest)        depth_d = depth_q + DEPTH_W'(1);
                    else if (unnest) depth_d = depth_q - DEPTH_W'(1);
                    // Match resumes execution just past the partner bracket in either direction.
                    if (unnest && depth_q == DEPTH_W'(1)) advance = 1'b1;
                    else if (!dir_q) begin advance = 1'b1; adv_state = S_SFETCH; end
                    else             retreat = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (pc_inc[IADDR_W]) begin
                error_d = 1'b1;
                state_d = S_HALT;
            end else begin
                pc_d    = pc_inc[IADDR_W-1:0];
                state_d = adv_state;
            end
        end
        if (retreat) begin
            if (pc_q == '0) begin
                error_d = 1'b1;
                state_d = S_HALT;
            end else begin
                pc_d    = pc_q - IADDR_W'(1);
                state_d = S_SFETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            dp_q    <= '0;
            depth_q <= '0;
            dir_q   <= 1'b0;
            op_q    <= '0;
            out_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dp_q    <= dp_d;
            depth_q <= depth_d;
            dir_q   <= dir_d;
            op_q    <= op_d;
            out_q   <= out_d;
            error_q <= error_d;
        end
    end

    // Handshake and ALU controls decode straight from state so reset drops them immediately.
    assign bus.imem_addr     = pc_q;
    assign bus.dmem_addr     = dp_q;
    assign bus.alu_a         = bus.dmem_rdata;
    assign bus.alu_increment = (state_q == S_EXEC) && (op_q == OP_INC);
    assign bus.alu_decrement = (state_q == S_EXEC) && (op_q == OP_DEC);
    assign bus.alu_nochange  = !(bus.alu_increment || bus.alu_decrement);
    assign bus.dmem_we       = bus.alu_increment || bus.alu_decrement ||
                               ((state_q == S_IN_WAIT) && bus.in_valid);
    assign bus.dmem_wdata    = !bus.dmem_we ? '0 :
                               (state_q == S_IN_WAIT) ? bus.in_data : bus.alu_out;
    assign bus.out_valid     = (state_q == S_OUT_WAIT);
    assign bus.out_data      = out_q;
    assign bus.in_ready      = (state_q == S_IN_WAIT);

    assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done  = (state_q == S_HALT);
    assign error = error_q;
endmodule

// File: tb/tb_bf_control.sv
// Directed bench for bf_control: ROM/RAM/ALU/IO models around the sequencer, one task per scenario.
module tb_bf_control;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, error;

    always #5 clk = ~clk;

    bf_control_if #(.WIDTH(8), .IADDR_W(10), .DADDR_W(8)) bus ();

    bf_control #(.WIDTH(8), .IADDR_W(10), .DADDR_W(8), .DEPTH_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    logic [7:0] imem [1024];
    logic [7:0] dmem [256];
    logic       mem_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    int out_count = 0, out_vcycles = 0, out_unstable = 0, out_hold = 0, out_stall = 0;
    logic [7:0] last_out = 8'h00, out_first = 8'h00;
    int in_total = 0, in_run = 0, in_delay = 1;
    int wr_count = 0, alu_bad = 0;

    // Instruction ROM and data RAM, both with one-cycle read latency.
    always @(posedge clk) begin
        bus.imem_data  <= imem[bus.imem_addr];
        bus.dmem_rdata <= dmem[bus.dmem_addr];
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        end else if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            wr_count++;
        end
        if (bus.out_valid && bus.out_ready) begin
            out_count++;
            last_out = bus.out_data;
        end
    end

    assign bus.alu_out = bus.alu_increment ? bus.alu_a + 8'd1 :
                         bus.alu_decrement ? bus.alu_a - 8'd1 : bus.alu_a;

    // Output sink: stalls out_stall cycles, then accepts; also watches data stability.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            out_hold++;
            out_vcycles++;
            if (out_hold == 1) out_first = bus.out_data;
            else if (bus.out_data !== out_first) out_unstable++;
            bus.out_ready = (out_hold > out_stall);
        end else begin
            out_hold = 0;
            bus.out_ready = 1'b0;
        end
    end

    // Input source: offers the byte on the in_delay-th cycle of in_ready.
    always @(negedge clk) begin
        bus.in_data = 8'h41;
        if (bus.in_ready) begin
            in_run++;
            in_total++;
            bus.in_valid = (in_run >= in_delay);
        end else begin
            in_run = 0;
            bus.in_valid = 1'b0;
        end
        if (rst_n && ($countones({bus.alu_nochange, bus.alu_increment, bus.alu_decrement}) != 1))
            alu_bad++;
    end

    task automatic load_prog(input string s);
        for (int i = 0; i < 1024; i++) imem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) imem[i] = s[i];
    endtask

    task automatic clear_dmem();
        @(negedge clk) mem_clr = 1'b1;
        @(negedge clk) mem_clr = 1'b0;
    endtask

    // Cycle count = rising edges from the edge that samples start up to the one entering HALT.
    task automatic run_prog(output int cyc);
        @(negedge clk) start = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done) break;
            if (cyc >= 5000) begin
                checks++; errors++;
                $display("FAIL run_timeout got busy=%0b done=%0b exp done=1 within 5000 cycles", busy, done);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b exp 0", error); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); end
        checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem_we got %0b exp 0", bus.dmem_we); end
        checks++; if (bus.alu_nochange !== 1'b1) begin errors++; $display("FAIL reset_alu_nochange got %0b exp 1", bus.alu_nochange); end
        checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr got %0h exp 0", bus.imem_addr); end
        checks++; if (bus.dmem_addr !== 8'd0) begin errors++; $display("FAIL reset_dmem_addr got %0h exp 0", bus.dmem_addr); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", busy); end
    endtask

    task automatic test_timing();
        int cyc;
        load_prog(">"); clear_dmem(); run_prog(cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL timing_move got %0d exp 5", cyc); end
        load_prog("+"); clear_dmem(); run_prog(cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL timing_inc got %0d exp 6", cyc); end
        load_prog("+["); clear_dmem(); run_prog(cyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL timing_open_not_taken got %0d exp 9", cyc); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timing_error got %0b exp 0", error); end
    endtask

    task automatic test_inc_out();
        int cyc, o0;
        load_prog("+++."); clear_dmem(); o0 = out_count; run_prog(cyc);
        checks++; if (out_count - o0 !== 1) begin errors++; $display("FAIL inc_out_beats got %0d exp 1", out_count - o0); end
        checks++; if (last_out !== 8'h03) begin errors++; $display("FAIL inc_out_data got %0h exp 03", last_out); end
        checks++; if (dmem[0] !== 8'h03) begin errors++; $display("FAIL inc_out_cell0 got %0h exp 03", dmem[0]); end
        checks++; if (cyc !== 16) begin errors++; $display("FAIL inc_out_cycles got %0d exp 16", cyc); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL inc_out_halt got done=%0b busy=%0b exp done=1 busy=0", done, busy); end
    endtask

    task automatic test_wrap();
        int cyc;
        load_prog("-."); clear_dmem(); run_prog(cyc);
        checks++; if (last_out !== 8'hFF) begin errors++; $display("FAIL wrap_dec_data got %0h exp ff", last_out); end
        checks++; if (dmem[0] !== 8'hFF) begin errors++; $display("FAIL wrap_dec_cell0 got %0h exp ff", dmem[0]); end
        load_prog("<+>"); clear_dmem(); run_prog(cyc);
        checks++; if (dmem[255] !== 8'h01) begin errors++; $display("FAIL wrap_dp_cellff got %0h exp 01", dmem[255]); end
        checks++; if (dmem[0] !== 8'h00) begin errors++; $display("FAIL wrap_dp_cell0 got %0h exp 00", dmem[0]); end
        checks++; if (cyc !== 10) begin errors++; $display("FAIL wrap_dp_cycles got %0d exp 10", cyc); end
    endtask

    task automatic test_loop();
        int cyc, w0;
        load_prog("++[->+<]>."); clear_dmem(); w0 = wr_count; run_prog(cyc);
        checks++; if (last_out !== 8'h02) begin errors++; $display("FAIL loop_data got %0h exp 02", last_out); end
        checks++; if (wr_count - w0 !== 6) begin errors++; $display("FAIL loop_writes got %0d exp 6", wr_count - w0); end
        checks++; if (dmem[0] !== 8'h00 || dmem[1] !== 8'h02) begin errors++; $display("FAIL loop_cells got %0h/%0h exp 00/02", dmem[0], dmem[1]); end
        checks++; if (cyc !== 54) begin errors++; $display("FAIL loop_cycles got %0d exp 54", cyc); end
    endtask

    task automatic test_fwd_scan();
        int cyc, w0, o0;
        load_prog("[[+]]."); clear_dmem(); w0 = wr_count; o0 = out_count; run_prog(cyc);
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL fwd_scan_writes got %0d exp 0", wr_count - w0); end
        checks++; if (out_count - o0 !== 1 || last_out !== 8'h00) begin errors++; $display("FAIL fwd_scan_out got %0d beats data %0h exp 1 beat data 00", out_count - o0, last_out); end
        checks++; if (cyc !== 18) begin errors++; $display("FAIL fwd_scan_cycles got %0d exp 18", cyc); end
    endtask

    task automatic test_handshake();
        int cyc, i0, v0, u0;
        load_prog(",."); clear_dmem();
        in_delay = 5; out_stall = 3;
        i0 = in_total; v0 = out_vcycles; u0 = out_unstable;
        run_prog(cyc);
        checks++; if (in_total - i0 !== 5) begin errors++; $display("FAIL hs_in_ready_cycles got %0d exp 5", in_total - i0); end
        checks++; if (dmem[0] !== 8'h41) begin errors++; $display("FAIL hs_cell0 got %0h exp 41", dmem[0]); end
        checks++; if (last_out !== 8'h41) begin errors++; $display("FAIL hs_out_data got %0h exp 41", last_out); end
        checks++; if (out_vcycles - v0 !== 4) begin errors++; $display("FAIL hs_out_valid_cycles got %0d exp 4", out_vcycles - v0); end
        checks++; if (out_unstable - u0 !== 0) begin errors++; $display("FAIL hs_out_stable got %0d changes exp 0", out_unstable - u0); end
        checks++; if (cyc !== 18) begin errors++; $display("FAIL hs_cycles got %0d exp 18", cyc); end
        in_delay = 1; out_stall = 0;
    endtask

    task automatic test_bracket_error();
        int cyc;
        load_prog("+]"); clear_dmem(); run_prog(cyc);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL underrun_error got %0b exp 1", error); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL underrun_halt got done=%0b busy=%0b exp 1/0", done, busy); end
        checks++; if (cyc !== 9) begin errors++; $display("FAIL underrun_cycles got %0d exp 9", cyc); end
        load_prog(">"); clear_dmem(); run_prog(cyc);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_clear got %0b exp 0", error); end
    endtask

    task automatic test_depth_overflow();
        int cyc;
        for (int i = 0; i < 1024; i++) imem[i] = (i < 256) ? 8'h5B : 8'h00;
        clear_dmem(); run_prog(cyc);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL depth_ovf_error got %0b exp 1", error); end
        checks++; if (cyc !== 514) begin errors++; $display("FAIL depth_ovf_cycles got %0d exp 514", cyc); end
    endtask

    task automatic test_pc_overrun();
        int cyc;
        for (int i = 0; i < 1024; i++) imem[i] = 8'h20;
        clear_dmem(); run_prog(cyc);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL pc_ovr_error got %0b exp 1", error); end
        checks++; if (cyc !== 2049) begin errors++; $display("FAIL pc_ovr_cycles got %0d exp 2049", cyc); end
    endtask

    task automatic test_reset_mid_out();
        int n;
        load_prog("."); clear_dmem();
        out_stall = 1000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_reach got out_valid=%0b exp 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_status got busy=%0b done=%0b exp 0/0", busy, done); end
        @(negedge clk) rst_n = 1'b1;
        out_stall = 0;
        @(negedge clk);
    endtask

    initial begin
        start = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_timing();
        test_inc_out();
        test_wrap();
        test_loop();
        test_fwd_scan();
        test_handshake();
        test_bracket_error();
        test_depth_overflow();
        test_pc_overrun();
        test_reset_mid_out();
        checks++; if (alu_bad !== 0) begin errors++; $display("FAIL alu_onehot got %0d bad cycles exp 0", alu_bad); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bf_control.md
Name: bf_control

Overview:
- Instruction sequencer for the brainfuck core.
- Fetches 8-bit ASCII opcodes from instruction memory, decodes them and drives the shared increment/decrement ALU and the data-cell memory.
- Moves the data pointer, resolves loops by bracket scanning with a depth counter, and runs valid/ready handshakes for '.' output and ',' input.
- Sits between the instruction ROM, the data RAM, the ALU and the I/O ports.

Parameters:
- WIDTH, 8, data cell and ALU width.
- IADDR_W, 10, instruction address width.
- DADDR_W, 8, data pointer width.
- DEPTH_W, 8, bracket-scan depth counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins execution from pc=0, dp=0.
- imem_addr  output  IADDR_W  instruction address; synchronous ROM, data valid the following cycle.
- imem_data  input  8  opcode at the previous cycle's imem_addr.
- dmem_addr  output  DADDR_W  data cell address (= dp).
- dmem_rdata  input  WIDTH  cell read data; synchronous, 1-cycle latency.
- dmem_wdata  output  WIDTH  write data.
- dmem_we  output  1  write enable.
- alu_a  output  WIDTH  ALU operand (= dmem_rdata).
- alu_nochange  output  1  ALU pass-through select.
- alu_decrement  output  1  ALU decrement select.
- alu_increment  output  1  ALU increment select.
- alu_out  input  WIDTH  ALU result.
- out_valid  output  1  output byte valid.
- out_data  output  WIDTH  output byte.
- out_ready  input  1  sink accepts the output byte.
- in_valid  input  1  input byte valid.
- in_data  input  WIDTH  input byte.
- in_ready  output  1  controller accepts an input byte.
- busy  output  1  high from start until halt.
- done  output  1  high in HALT.
- error  output  1  sticky; unmatched bracket, depth overflow or pc overrun.

Behaviour:
- Reset (asynchronous): state IDLE; pc=0, dp=0, depth=0. All outputs 0 except alu_nochange=1.
- States: IDLE, FETCH, DECODE, EXEC, OUT_WAIT, IN_WAIT, SFETCH, SCHECK, HALT.
- IDLE/HALT: start -> pc=0, dp=0, clear done and error, go to FETCH. Data RAM is not cleared. start is ignored in all other states.
- FETCH: imem_addr=pc. Next state DECODE.
- DECODE: imem_data is valid; dmem_addr=dp issues the cell read.
  - '>' (0x3E): dp+1, pc+1 -> FETCH.
  - '<' (0x3C): dp-1, pc+1 -> FETCH.
  - dp wraps modulo 2^DADDR_W.
  - 0x00: HALT.
  - Any other byte not listed below: nop, pc+1 -> FETCH.
  - '+', '-', '.', ',', '[', ']' -> EXEC.
- EXEC: cell value = dmem_rdata.
  - '+' (0x2B): alu_increment=1, alu_nochange=0. '-' (0x2D): alu_decrement=1, alu_nochange=0. Both: dmem_we=1, dmem_wdata=alu_out, pc+1 -> FETCH. Exactly one ALU select is high in any cycle.
  - '.' (0x2E): -> OUT_WAIT.
  - ',' (0x2C): -> IN_WAIT.
  - '[' (0x5B): cell!=0 -> pc+1 -> FETCH. cell==0 -> depth=1, dir=fwd, pc+1 -> SFETCH.
  - ']' (0x5D): cell==0 -> pc+1 -> FETCH. cell!=0 -> depth=1, dir=bwd, pc-1 -> SFETCH.
- Instruction cycle counts: '<' '>' nop take 2 cycles; '+' '-' and non-taken brackets take 3.
- OUT_WAIT: out_valid=1, out_data=cell value registered in EXEC. Held stable until out_ready. On the transfer cycle: out_valid drops next cycle, pc+1 -> FETCH.
- IN_WAIT: in_ready=1. On the cycle in_valid=1: dmem_we=1, dmem_wdata=in_data, pc+1 -> FETCH.
- SFETCH: imem_addr=pc -> SCHECK.
- SCHECK, forward scan:
  - '[' -> depth+1; ']' -> depth-1.
  - If depth reaches 0: pc = matching pc+1 -> FETCH. Otherwise pc+1 -> SFETCH.
- SCHECK, backward scan:
  - ']' -> depth+1; '[' -> depth-1.
  - If depth reaches 0: pc = matching pc+1 -> FETCH. Otherwise pc-1 -> SFETCH.
- Errors (error=1 -> HALT):
  - 0x00 during a scan.
  - pc decrement below 0 or increment past 2^IADDR_W-1 during a scan or in normal flow.
  - depth increment beyond 2^DEPTH_W-1.
- HALT: done=1, busy=0; error holds. Leaves HALT only on start.
- Reset mid-operation: immediate return to IDLE. A pending handshake is abandoned; out_valid and in_ready drop asynchronously.

Test Plan:
- Program "+++." with the bench ALU adding/subtracting 1 and out_ready=1 -> one out_valid beat with out_data=0x03, then done=1; cell 0 = 0x03.
- Program "-." -> out_data=0xFF (wrap); program "<+>" -> cell 0xFF = 0x01, cell 0 unchanged.
- Program "++[->+<]>." -> out_data=0x02; loop body runs twice; backward scan taken once, each scan from ']' to its '['.
- Program "[[+]]." with cell 0 = 0 -> forward scan over the nested brackets, no cell writes, out_data=0x00.
- Program ",." with in_valid delayed 5 cycles, then in_data=0x41; out_ready held low 3 cycles -> in_ready high for 5 cycles; out_valid and out_data=0x41 stable until accepted.
- Program "+]" -> error=1, done=1 after the backward scan underruns pc. Assert rst_n low mid-OUT_WAIT -> out_valid=0 immediately, busy=0.
